// File: rtl/counter_rw_latch.sv
// counter_rw_latch: bus-side front end of one timer channel.
// Assembles control-word and count-byte writes into the programming signals
// for the counting element, and serves count reads with latch semantics.
// Optional build macro: READBACK_EN adds the read-back command and the out_in port.
module counter_rw_latch #(
    parameter logic [2:0] RESET_MODE = 3'd0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  data_in,
    input  logic        ctrl_wr,
    input  logic        wr_count,
    input  logic        rd_count,
    output logic [7:0]  data_out,
    input  logic [15:0] current_count,
    input  logic        count_loaded,
    output logic [15:0] initial_count,
    output logic        counter_programmed,
    output logic [1:0]  RW,
    output logic [2:0]  mode,
    output logic        BCD,
`ifdef READBACK_EN
    input  logic        out_in,
`endif
    output logic        null_count
);

    logic [1:0]  rw_q, rw_d;
    logic [2:0]  mode_q, mode_d;
    logic        bcd_q, bcd_d;
    logic [15:0] initCount_q, initCount_d;
    logic        programmed_q, programmed_d;
    logic        nullCount_q, nullCount_d;
    logic        writePtr_q, writePtr_d;
    logic        readPtr_q, readPtr_d;
    logic [7:0]  staged_q, staged_d;
    logic [15:0] latch_q, latch_d;
    logic        latchHeld_q, latchHeld_d;
    logic        statusActive;
    logic [15:0] readSource;
`ifdef READBACK_EN
    logic [7:0]  status_q, status_d;
    logic        statusHeld_q, statusHeld_d;

    assign statusActive = statusHeld_q;
`else
    assign statusActive = 1'b0;
`endif

    // State register; reset returns the channel to unprogrammed with no latch held.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rw_q         <= 2'b00;
            mode_q       <= RESET_MODE;
            bcd_q        <= 1'b0;
            initCount_q  <= 16'h0000;
            programmed_q <= 1'b0;
            nullCount_q  <= 1'b0;
            writePtr_q   <= 1'b0;
            readPtr_q    <= 1'b0;
            staged_q     <= 8'h00;
            latch_q      <= 16'h0000;
            latchHeld_q  <= 1'b0;
`ifdef READBACK_EN
            status_q     <= 8'h00;
            statusHeld_q <= 1'b0;
`endif
        end else begin
            rw_q         <= rw_d;
            mode_q       <= mode_d;
            bcd_q        <= bcd_d;
            initCount_q  <= initCount_d;
            programmed_q <= programmed_d;
            nullCount_q  <= nullCount_d;
            writePtr_q   <= writePtr_d;
            readPtr_q    <= readPtr_d;
            staged_q     <= staged_d;
            latch_q      <= latch_d;
            latchHeld_q  <= latchHeld_d;
`ifdef READBACK_EN
            status_q     <= status_d;
            statusHeld_q <= statusHeld_d;
`endif
        end
    end

    // Next state: reads act on pre-command state, then writes, control words and latches.
    always_comb begin
        rw_d         = rw_q;
        mode_d       = mode_q;
        bcd_d        = bcd_q;
        initCount_d  = initCount_q;
        programmed_d = 1'b0;
        nullCount_d  = nullCount_q;
        writePtr_d   = writePtr_q;
        readPtr_d    = readPtr_q;
        staged_d     = staged_q;
        latch_d      = latch_q;
        latchHeld_d  = latchHeld_q;
`ifdef READBACK_EN
        status_d     = status_q;
        statusHeld_d = statusHeld_q;
`endif

        if (count_loaded && !programmed_q) begin
            nullCount_d = 1'b0;
        end

        if (rd_count && (rw_q != 2'b00)) begin
            if (statusActive) begin
`ifdef READBACK_EN
                statusHeld_d = 1'b0;
`endif
            end else if (rw_q == 2'b11) begin
                readPtr_d = ~readPtr_q;
                if (readPtr_q) begin
                    latchHeld_d = 1'b0;
                end
            end else begin
                latchHeld_d = 1'b0;
            end
        end

        if (wr_count && !ctrl_wr && (rw_q != 2'b00)) begin
            case (rw_q)
                2'b01: begin
                    initCount_d  = {8'h00, data_in};
                    programmed_d = 1'b1;
                    nullCount_d  = 1'b1;
                end
                2'b10: begin
                    initCount_d  = {data_in, 8'h00};
                    programmed_d = 1'b1;
                    nullCount_d  = 1'b1;
                end
                default: begin
                    if (!writePtr_q) begin
                        staged_d   = data_in;
                        writePtr_d = 1'b1;
                    end else begin
                        initCount_d  = {data_in, staged_q};
                        programmed_d = 1'b1;
                        nullCount_d  = 1'b1;
                        writePtr_d   = 1'b0;
                    end
                end
            endcase
        end

        if (ctrl_wr && (data_in[7:6] != 2'b11)) begin
            if (data_in[5:4] != 2'b00) begin
                rw_d        = data_in[5:4];
                mode_d      = data_in[3:1];
                bcd_d       = data_in[0];
                writePtr_d  = 1'b0;
                readPtr_d   = 1'b0;
                latchHeld_d = 1'b0;
                nullCount_d = 1'b1;
            end else if (!latchHeld_d) begin
                latch_d     = current_count;
                latchHeld_d = 1'b1;
            end
        end

`ifdef READBACK_EN
        if (ctrl_wr && (data_in[7:6] == 2'b11)) begin
            if (!data_in[5] && !latchHeld_d) begin
                latch_d     = current_count;
                latchHeld_d = 1'b1;
            end
            if (!data_in[4] && !statusHeld_d) begin
                status_d     = {out_in, nullCount_q, rw_q, mode_q, bcd_q};
                statusHeld_d = 1'b1;
            end
        end
`endif
    end

    // Read data: status byte first if held, else the selected byte of latch or live count.
    always_comb begin
        readSource = latchHeld_q ? latch_q : current_count;
        data_out   = 8'h00;
        if (rw_q != 2'b00) begin
            if (statusActive) begin
`ifdef READBACK_EN
                data_out = status_q;
`endif
            end else begin
                case (rw_q)
                    2'b01:   data_out = readSource[7:0];
                    2'b10:   data_out = readSource[15:8];
                    default: data_out = readPtr_q ? readSource[15:8] : readSource[7:0];
                endcase
            end
        end
    end

    assign initial_count      = initCount_q;
    assign counter_programmed = programmed_q;
    assign RW                 = rw_q;
    assign mode               = mode_q;
    assign BCD                = bcd_q;
    assign null_count         = nullCount_q;

endmodule

// File: tb/tb_counter_rw_latch.sv
// tb_counter_rw_latch: scoreboard bench for the counter_rw_latch channel front end.
module tb_counter_rw_latch;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        ctrl_wr = 1'b0;
    logic        wr_count = 1'b0;
    logic        rd_count = 1'b0;
    logic [7:0]  data_out;
    logic [15:0] current_count = 16'h0000;
    logic        count_loaded = 1'b0;
    logic [15:0] initial_count;
    logic        counter_programmed;
    logic [1:0]  RW;
    logic [2:0]  mode;
    logic        BCD;
    logic        null_count;
`ifdef READBACK_EN
    logic        out_in = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] expCountQ[$];
    logic [7:0]  expReadQ[$];

    counter_rw_latch dut (
        .CLK                (CLK),
        .RST                (RST),
        .data_in            (data_in),
        .ctrl_wr            (ctrl_wr),
        .wr_count           (wr_count),
        .rd_count           (rd_count),
        .data_out           (data_out),
        .current_count      (current_count),
        .count_loaded       (count_loaded),
        .initial_count      (initial_count),
        .counter_programmed (counter_programmed),
        .RW                 (RW),
        .mode               (mode),
        .BCD                (BCD),
`ifdef READBACK_EN
        .out_in             (out_in),
`endif
        .null_count         (null_count)
    );

    // Free-running clock, 10 time-unit period.
    always #5 CLK = ~CLK;

    task automatic applyCtrl(input logic [7:0] b);
        @(negedge CLK);
        ctrl_wr = 1'b1;
        data_in = b;
        @(negedge CLK);
        ctrl_wr = 1'b0;
        data_in = 8'h00;
        #1;
    endtask

    task automatic applyWrite(input logic [7:0] b, output logic pulse, output logic [15:0] ic);
        @(negedge CLK);
        wr_count = 1'b1;
        data_in  = b;
        @(negedge CLK);
        wr_count = 1'b0;
        data_in  = 8'h00;
        #1;
        pulse = counter_programmed;
        ic    = initial_count;
    endtask

    task automatic applyRead(output logic [7:0] d);
        @(negedge CLK);
        rd_count = 1'b1;
        #1;
        d = data_out;
        @(negedge CLK);
        rd_count = 1'b0;
    endtask

    task automatic test_reset;
        logic pulse;
        logic [15:0] ic;
        current_count = 16'h1234;
        #1;
        checks++;
        if ({initial_count, RW, mode, BCD, counter_programmed, null_count} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_state got ic=%h rw=%b mode=%0d bcd=%b cp=%b nc=%b required all zero",
                     initial_count, RW, mode, BCD, counter_programmed, null_count);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data_out got %h required 00", data_out);
        end
        @(negedge CLK);
        RST = 1'b0;
        applyWrite(8'h55, pulse, ic);
        checks++;
        if (pulse !== 1'b0 || ic !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL unprog_write got cp=%b ic=%h required cp=0 ic=0000", pulse, ic);
        end
    endtask

    task automatic test_two_byte;
        logic pulse;
        logic [15:0] ic;
        logic [15:0] exp;
        applyCtrl(8'h34);
        checks++;
        if (RW !== 2'b11 || mode !== 3'd2 || BCD !== 1'b0 || null_count !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ctrl34 got rw=%b mode=%0d bcd=%b nc=%b required 11/2/0/1", RW, mode, BCD, null_count);
        end
        applyWrite(8'h10, pulse, ic);
        checks++;
        if (pulse !== 1'b0 || ic !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL first_byte got cp=%b ic=%h required cp=0 ic=0000", pulse, ic);
        end
        expCountQ.push_back(16'h2710);
        applyWrite(8'h27, pulse, ic);
        exp = expCountQ.pop_front();
        checks++;
        if (pulse !== 1'b1 || ic !== exp) begin
            errors++;
            $display("[TB] FAIL second_byte got cp=%b ic=%h required cp=1 ic=%h", pulse, ic, exp);
        end
        @(negedge CLK);
        #1;
        checks++;
        if (counter_programmed !== 1'b0 || null_count !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pulse_width got cp=%b nc=%b required cp=0 nc=1", counter_programmed, null_count);
        end
        count_loaded = 1'b1;
        @(negedge CLK);
        count_loaded = 1'b0;
        #1;
        checks++;
        if (null_count !== 1'b0) begin
            errors++;
            $display("[TB] FAIL null_clear got %b required 0", null_count);
        end
    endtask

    task automatic test_single_byte;
        logic pulse;
        logic [15:0] ic;
        logic [15:0] exp;
        applyCtrl(8'h14);
        expCountQ.push_back(16'h0055);
        applyWrite(8'h55, pulse, ic);
        exp = expCountQ.pop_front();
        checks++;
        if (pulse !== 1'b1 || ic !== exp || RW !== 2'b01) begin
            errors++;
            $display("[TB] FAIL lsb_only got cp=%b ic=%h rw=%b required cp=1 ic=%h rw=01", pulse, ic, RW, exp);
        end
        applyCtrl(8'h24);
        expCountQ.push_back(16'hAA00);
        applyWrite(8'hAA, pulse, ic);
        exp = expCountQ.pop_front();
        checks++;
        if (pulse !== 1'b1 || ic !== exp || RW !== 2'b10) begin
            errors++;
            $display("[TB] FAIL msb_only got cp=%b ic=%h rw=%b required cp=1 ic=%h rw=10", pulse, ic, RW, exp);
        end
    endtask

    task automatic test_latch;
        logic [7:0] got;
        logic [7:0] exp;
        applyCtrl(8'h34);
        current_count = 16'h1234;
        applyCtrl(8'h00);
        checks++;
        if (RW !== 2'b11 || mode !== 3'd2) begin
            errors++;
            $display("[TB] FAIL latch_keeps_ctrl got rw=%b mode=%0d required 11/2", RW, mode);
        end
        current_count = 16'h1200;
        expReadQ.push_back(8'h34);
        expReadQ.push_back(8'h12);
        expReadQ.push_back(8'h00);
        for (int i = 0; i < 3; i++) begin
            applyRead(got);
            exp = expReadQ.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL latch_read%0d got %h required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_first_latch_wins;
        logic [7:0] got;
        logic [7:0] exp;
        applyCtrl(8'h34);
        current_count = 16'h0100;
        applyCtrl(8'h00);
        current_count = 16'h00FF;
        applyCtrl(8'h00);
        current_count = 16'h7777;
        expReadQ.push_back(8'h00);
        expReadQ.push_back(8'h01);
        expReadQ.push_back(8'h77);
        for (int i = 0; i < 3; i++) begin
            applyRead(got);
            exp = expReadQ.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL first_wins_read%0d got %h required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_ctrl_abort;
        logic pulse;
        logic [15:0] ic;
        logic [15:0] exp;
        applyCtrl(8'h34);
        applyWrite(8'h99, pulse, ic);
        applyCtrl(8'h34);
        applyWrite(8'h01, pulse, ic);
        checks++;
        if (pulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_lsb got cp=%b required 0", pulse);
        end
        expCountQ.push_back(16'h0001);
        applyWrite(8'h00, pulse, ic);
        exp = expCountQ.pop_front();
        checks++;
        if (pulse !== 1'b1 || ic !== exp) begin
            errors++;
            $display("[TB] FAIL abort_commit got cp=%b ic=%h required cp=1 ic=%h", pulse, ic, exp);
        end
    endtask

    task automatic test_simultaneous;
        logic [7:0] got;
        logic [7:0] exp;
        @(negedge CLK);
        ctrl_wr  = 1'b1;
        wr_count = 1'b1;
        data_in  = 8'h14;
        @(negedge CLK);
        ctrl_wr  = 1'b0;
        wr_count = 1'b0;
        data_in  = 8'h00;
        #1;
        checks++;
        if (counter_programmed !== 1'b0 || RW !== 2'b01 || initial_count !== 16'h0001) begin
            errors++;
            $display("[TB] FAIL ctrl_beats_write got cp=%b rw=%b ic=%h required cp=0 rw=01 ic=0001",
                     counter_programmed, RW, initial_count);
        end
        applyCtrl(8'h34);
        current_count = 16'hABCD;
        expReadQ.push_back(8'hCD);
        expReadQ.push_back(8'hAB);
        expReadQ.push_back(8'h00);
        @(negedge CLK);
        ctrl_wr  = 1'b1;
        rd_count = 1'b1;
        data_in  = 8'h00;
        #1;
        got = data_out;
        @(negedge CLK);
        ctrl_wr  = 1'b0;
        rd_count = 1'b0;
        current_count = 16'h0000;
        exp = expReadQ.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL latch_with_read got %h required %h", got, exp);
        end
        for (int i = 0; i < 2; i++) begin
            applyRead(got);
            exp = expReadQ.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL after_latch_read%0d got %h required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp;
        applyCtrl(8'h14);
        expCountQ.push_back(16'h0001);
        expCountQ.push_back(16'h0002);
        @(negedge CLK);
        wr_count = 1'b1;
        data_in  = 8'h01;
        @(negedge CLK);
        data_in  = 8'h02;
        for (int i = 0; i < 2; i++) begin
            #1;
            exp = expCountQ.pop_front();
            checks++;
            if (counter_programmed !== 1'b1 || initial_count !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_commit%0d got cp=%b ic=%h required cp=1 ic=%h", i, counter_programmed, initial_count, exp);
            end
            @(negedge CLK);
            wr_count = 1'b0;
            data_in  = 8'h00;
        end
        #1;
        checks++;
        if (counter_programmed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end got cp=%b required 0", counter_programmed);
        end
    endtask

    task automatic test_reset_mid;
        logic pulse;
        logic [15:0] ic;
        logic [15:0] exp;
        applyCtrl(8'h34);
        applyWrite(8'h77, pulse, ic);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (RW !== 2'b00 || initial_count !== 16'h0000 || null_count !== 1'b0 || mode !== 3'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got rw=%b ic=%h nc=%b mode=%0d required 00/0000/0/0", RW, initial_count, null_count, mode);
        end
        @(negedge CLK);
        RST = 1'b0;
        applyCtrl(8'h34);
        applyWrite(8'h01, pulse, ic);
        expCountQ.push_back(16'h0201);
        applyWrite(8'h02, pulse, ic);
        exp = expCountQ.pop_front();
        checks++;
        if (pulse !== 1'b1 || ic !== exp) begin
            errors++;
            $display("[TB] FAIL post_reset_commit got cp=%b ic=%h required cp=1 ic=%h", pulse, ic, exp);
        end
    endtask

`ifdef READBACK_EN
    task automatic test_readback;
        logic pulse;
        logic [15:0] ic;
        logic [7:0] got;
        logic [7:0] exp;
        applyCtrl(8'h36);
        applyWrite(8'h34, pulse, ic);
        applyWrite(8'h12, pulse, ic);
        @(negedge CLK);
        count_loaded = 1'b1;
        @(negedge CLK);
        count_loaded = 1'b0;
        out_in = 1'b1;
        current_count = 16'h4321;
        applyCtrl(8'hE2);
        expReadQ.push_back(8'hB6);
        expReadQ.push_back(8'h21);
        expReadQ.push_back(8'h43);
        for (int i = 0; i < 3; i++) begin
            applyRead(got);
            exp = expReadQ.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL readback_read%0d got %h required %h", i, got, exp);
            end
        end
    endtask
`endif

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_two_byte();
        test_single_byte();
        test_latch();
        test_first_latch_wins();
        test_ctrl_abort();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
`ifdef READBACK_EN
        test_readback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
